// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU built-in self-test controller.
//   - alu_op_e     : ALU opcode encoding (MUL/SUB/AND/XOR)
//   - bist_state_e : controller FSM states
//   - alu_resp_t   : packed ALU response {r, z, n, c, v}
//   - widths and the vector count of one full sweep
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int OPW       = 4;     // operand width
    localparam int RESW      = 8;     // result width
    localparam int VEC_COUNT = 1024;  // 4 ops x 16 a x 16 b
    localparam int IDX_W     = 10;    // {op, a, b}
    localparam int ERR_W     = 11;    // holds 0..VEC_COUNT
    localparam int RESP_W    = RESW + 4;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } bist_state_e;

    typedef struct packed {
        logic [RESW-1:0] r;
        logic            z;
        logic            n;
        logic            c;
        logic            v;
    } alu_resp_t;

endpackage

// File: rtl/alu_golden.sv
// -----------------------------------------------------------------------------
// alu_golden
// Purely combinational reference ALU: expected response for one vector.
// Ports:
//   op   in  2   opcode (alu_op_e encoding)
//   a, b in  4   operands
//   resp out 12  expected {r, z, n, c, v}
// -----------------------------------------------------------------------------
module alu_golden
    import alu_pkg::*;
(
    input  logic [1:0]     op,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output alu_resp_t      resp
);

    // A + ~B + 1: bit 4 is the borrow-free carry, i.e. A >= B unsigned
    logic [OPW:0]    diff;
    logic [RESW-1:0] prod;

    always_comb begin
        diff = {1'b0, a} + {1'b0, ~b} + 5'd1;
        prod = {4'b0, a} * {4'b0, b};
        resp = '0;
        case (alu_op_e'(op))
            OP_MUL: resp.r = prod;
            OP_SUB: begin
                resp.r = {4'b0, diff[OPW-1:0]};
                resp.n = diff[OPW-1];
                resp.c = diff[OPW];
                // overflow: operands of differing sign and result sign != a's sign
                resp.v = (a[OPW-1] ^ b[OPW-1]) & (diff[OPW-1] ^ a[OPW-1]);
            end
            OP_AND: resp.r = {4'b0, a & b};
            default: resp.r = {4'b0, a ^ b};
        endcase
        resp.z = (resp.r == '0);
    end

endmodule

// File: rtl/alu_bist_ctrl.sv
// -----------------------------------------------------------------------------
// alu_bist_ctrl
// Self-test sweep controller for a 4-bit combinational ALU. On an accepted
// start it drives all 1024 {op,a,b} vectors (op outer, b inner), compares the
// ALU response against alu_golden one cycle later, counts mismatching vectors
// and latches the first failing vector.
// Build option: ALU_BIST_STOP_ON_FAIL_EN - end the sweep on the first mismatch.
// Ports:
//   clk, rst                in   clock, synchronous active-high reset
//   start                   in   one-cycle sweep request (IDLE/DONE only)
//   alu_a, alu_b, alu_op    out  registered vector drive (0 outside RUN)
//   alu_r, alu_z/n/c/v      in   ALU response
//   busy, done, pass        out  status (pass valid with done)
//   err_count               out  mismatching vector count
//   fail_op, fail_a, fail_b out  first mismatching vector
// -----------------------------------------------------------------------------
module alu_bist_ctrl
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [OPW-1:0]   alu_a,
    output logic [OPW-1:0]   alu_b,
    output logic [1:0]       alu_op,
    input  logic [RESW-1:0]  alu_r,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       fail_op,
    output logic [OPW-1:0]   fail_a,
    output logic [OPW-1:0]   fail_b
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

    bist_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic [OPW-1:0]   alu_a_q, alu_a_d;
    logic [OPW-1:0]   alu_b_q, alu_b_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [1:0]       fail_op_q, fail_op_d;
    logic [OPW-1:0]   fail_a_q, fail_a_d;
    logic [OPW-1:0]   fail_b_q, fail_b_d;

    alu_resp_t         exp_resp;
    logic [RESP_W-1:0] got_resp;
    logic [RESP_W-1:0] bit_diff;
    logic              mismatch;
    logic              stop_now;
    logic [IDX_W-1:0]  next_vec;

    // Expected response for the vector currently on the ALU inputs
    alu_golden u_golden (
        .op   (alu_op_q),
        .a    (alu_a_q),
        .b    (alu_b_q),
        .resp (exp_resp)
    );

    assign got_resp = {alu_r, alu_z, alu_n, alu_c, alu_v};

    // Per-field difference; any differing bit makes the whole vector count once
    for (genvar gi = 0; gi < RESP_W; gi++) begin : g_cmp
        assign bit_diff[gi] = got_resp[gi] ^ exp_resp[gi];
    end
    assign mismatch = |bit_diff;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        err_count_d = err_count_q;
        fail_op_d   = fail_op_q;
        fail_a_d    = fail_a_q;
        fail_b_d    = fail_b_q;
        stop_now    = 1'b0;
        next_vec    = idx_q + 1'b1;

        case (state_q)
            ST_RUN: begin
                if (mismatch) begin
                    err_count_d = err_count_q + 1'b1;
                    // zero count means this is the sweep's first mismatch
                    if (err_count_q == '0) begin
                        fail_op_d = alu_op_q;
                        fail_a_d  = alu_a_q;
                        fail_b_d  = alu_b_q;
                    end
                end
                stop_now = (idx_q == LAST_IDX);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
                stop_now = stop_now | mismatch;
`endif
                if (stop_now) begin
                    state_d  = ST_DONE;
                    alu_op_d = '0;
                    alu_a_d  = '0;
                    alu_b_d  = '0;
                end else begin
                    idx_d                         = next_vec;
                    {alu_op_d, alu_a_d, alu_b_d}  = next_vec;
                end
            end
            default: begin
                // IDLE, DONE and any unreachable encoding: wait for start
                if (start) begin
                    state_d     = ST_RUN;
                    idx_d       = '0;
                    alu_op_d    = '0;
                    alu_a_d     = '0;
                    alu_b_d     = '0;
                    err_count_d = '0;
                    fail_op_d   = '0;
                    fail_a_d    = '0;
                    fail_b_d    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            err_count_q <= '0;
            fail_op_q   <= '0;
            fail_a_q    <= '0;
            fail_b_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            err_count_q <= err_count_d;
            fail_op_q   <= fail_op_d;
            fail_a_q    <= fail_a_d;
            fail_b_q    <= fail_b_d;
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (err_count_q == '0);
    assign err_count = err_count_q;
    assign fail_op   = fail_op_q;
    assign fail_a    = fail_a_q;
    assign fail_b    = fail_b_q;

endmodule
